fpu_arbiter: RTL and testbench
==============================

# fpu_arbiter

Shares the single FPU instance between NREQ requesters (integer core execute stage, a future second issue slot, and a debug/loader port) so the FPU's one-outstanding-operation handshake is never violated. It sits between the requesters and the FPU's `in_valid`/`result_valid` ports. It does four things: round-robin arbitration, operand capture, exactly-one-cycle issue pulses, and result return to the owning requester. A watchdog guarantees forward progress if the FPU never answers.

## Interface
Parameters:
- NREQ, 2: number of requesters (2..4).
- TIMEOUT, 255: maximum cycles from issue to `fpu_result_valid` before abort (1..65535).

Ports. Per-requester buses are unpacked arrays `[NREQ]`. Reset is synchronous, active-high, on INITIALIZE; single clock CLK.
- CLK  in  1  clock.
- INITIALIZE  in  1  synchronous active-high reset.
- req_valid  in  [NREQ]x1  requester holds an operation.
- req_operator  in  [NREQ]x3  FPU operator code.
- req_subop  in  [NREQ]x3  compare subop.
- req_a, req_b  in  [NREQ]x32  operands.
- req_ready  out  [NREQ]x1  accept strobe; at most one bit high per cycle.
- resp_valid  out  [NREQ]x1  one-cycle result strobe to the owner.
- resp_err  out  1  qualifies resp_valid; 1 means timeout abort.
- resp_c  out  32  result word; 0 on error.
- fpu_in_valid  out  1  issue pulse.
- fpu_operator, fpu_subop  out  3 each.
- fpu_a, fpu_b  out  32 each.
- fpu_result_valid  in  1.
- fpu_c  in  32.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is high, grant g is the first set bit searching from `last_grant+1` modulo NREQ.
  - `req_ready[g]=1` combinationally in that cycle.
  - Operator, subop, a and b are registered onto the `fpu_*` outputs, `owner<=g`, `last_grant<=g`, then go to ISSUE.
- **ISSUE**
  - `fpu_in_valid=1` for this cycle only.
  - Timeout counter is cleared to 1.
  - If `fpu_result_valid=1`, capture `fpu_c` and go to RESP; otherwise go to WAIT.
- **WAIT**
  - If `fpu_result_valid=1`: capture `fpu_c`, `err<=0`, go to RESP.
  - Otherwise, if counter==TIMEOUT: `err<=1`, captured value 0, go to RESP.
  - Otherwise increment the counter.
- **RESP**
  - `resp_valid[owner]=1`, `resp_c`/`resp_err` driven from the capture registers.
  - Go to IDLE. No new grant is made in this cycle.
- Requesters must hold `req_*` stable while `req_valid=1` and `req_ready=0`. The arbiter never drops an accepted request.
- `fpu_result_valid` arriving in IDLE or RESP (late result after a timeout) is ignored. No state change, no response.
- `fpu_operator`, `fpu_subop`, `fpu_a` and `fpu_b` hold their values until the next grant.
- Operator codes: NEG 0, ADD 1, SUB 2, MUL 3, DIV 4, CMP 5. Subops: EQ 000, LE 010, LT 100. Codes are passed through unchecked.

## Timing
- Accept at cycle T; `fpu_in_valid` at T+1; result sampled at T+1+L (L≥0, the FPU latency); `resp_valid` at T+2+L; earliest next accept at T+3+L.
- Timeout response: `resp_valid` with `resp_err=1` at T+2+TIMEOUT.
- Reset values: all `req_ready`/`resp_valid` 0, `resp_err` 0, `resp_c` 0, `fpu_in_valid` 0, `fpu_*` operands 0, `busy` 0, state IDLE, `last_grant` NREQ-1 (requester 0 wins first).
- INITIALIZE mid-operation aborts without issuing a response. The next cycle is IDLE with reset values, and any FPU result still in flight is ignored.
- Simultaneous requests from all ports are granted in strict rotation, so each requester waits at most NREQ-1 operations.

## Structure
- Shared package `cpu_pkg`: FPU operator codes, compare subop codes, and the arbiter state enum.
- Sub-module `rr_arbiter` (NREQ-wide round-robin grant from a request vector and `last_grant`, combinational one-hot plus index). It is reused later for the output queue.

## Test plan
Bench FPU stub has fixed latency L=3 unless stated.
- Single request, req0 ADD a=0x3F800000, b=0x40000000 -> `req_ready[0]` at T, `fpu_in_valid` high exactly at T+1, `resp_valid[0]` at T+5 with `resp_c`=0x40400000 and `resp_err`=0.
- Both requesters continuously valid, 6 operations -> grants 0,1,0,1,0,1. `req_ready` is never multi-hot, and `fpu_in_valid` is never asserted while busy is in WAIT.
- CMP subop LT on req1, a=0xBF800000, b=0x00000000, stub L=0 (result in the ISSUE cycle) -> `resp_valid[1]` at T+2 with `resp_c`[0]=1.
- TIMEOUT=8 with the stub never answering -> `resp_valid[0]` at T+10 with `resp_err`=1 and `resp_c`=0. A stray `fpu_result_valid` 4 cycles later produces no response, and the next request is served normally.
- INITIALIZE asserted in WAIT -> the next cycle has all outputs at reset values, no `resp_valid`, and the following grant goes to requester 0.
- Requester drops nothing: a 1000-operation random mix with random stub latency 0..20 gives response count equal to accept count per port and results matching the reference model.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: FPU operator/subop codes and the FPU arbiter state type.
package cpu_pkg;

    localparam logic [2:0] FPU_OP_NEG = 3'd0;
    localparam logic [2:0] FPU_OP_ADD = 3'd1;
    localparam logic [2:0] FPU_OP_SUB = 3'd2;
    localparam logic [2:0] FPU_OP_MUL = 3'd3;
    localparam logic [2:0] FPU_OP_DIV = 3'd4;
    localparam logic [2:0] FPU_OP_CMP = 3'd5;

    localparam logic [2:0] FPU_CMP_EQ = 3'b000;
    localparam logic [2:0] FPU_CMP_LE = 3'b010;
    localparam logic [2:0] FPU_CMP_LT = 3'b100;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

    // Width of an index into n requesters (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester set after last_grant, wrapping modulo NREQ.
module rr_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_any
);

    logic [IW-1:0] cand;

    // Scan from last_grant+1 so the previous winner has lowest priority.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IW'((32'(last_grant) + i) % NREQ);
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one FPU between NREQ requesters with one operation outstanding at a time,
// round-robin fairness, and a watchdog that aborts an unanswered operation.
module fpu_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        INITIALIZE,
    input  logic        req_valid    [NREQ],
    input  logic [2:0]  req_operator [NREQ],
    input  logic [2:0]  req_subop    [NREQ],
    input  logic [31:0] req_a        [NREQ],
    input  logic [31:0] req_b        [NREQ],
    output logic        req_ready    [NREQ],
    output logic        resp_valid   [NREQ],
    output logic        resp_err,
    output logic [31:0] resp_c,
    output logic        fpu_in_valid,
    output logic [2:0]  fpu_operator,
    output logic [2:0]  fpu_subop,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic        fpu_result_valid,
    input  logic [31:0] fpu_c,
    output logic        busy
);

    localparam int unsigned IW = idx_width(NREQ);

    arb_state_t      state;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   grant_idx;
    logic [NREQ-1:0] req_vec;
    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic [15:0]     wait_cnt;

    // Flatten the per-requester valid array for the arbiter.
    always_comb begin
        req_vec = '0;
        for (int unsigned i = 0; i < NREQ; i++) req_vec[i] = req_valid[i];
    end

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req        (req_vec),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    // Accept strobe is only offered while idle, so it is one-hot or zero.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) req_ready[i] = (state == ARB_IDLE) && grant[i];
    end

    assign busy = (state != ARB_IDLE);

    // Control FSM; issue/response strobes are registered one-cycle pulses.
    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            state        <= ARB_IDLE;
            last_grant   <= IW'(NREQ - 1);
            owner        <= '0;
            wait_cnt     <= '0;
            fpu_in_valid <= 1'b0;
            fpu_operator <= '0;
            fpu_subop    <= '0;
            fpu_a        <= '0;
            fpu_b        <= '0;
            resp_err     <= 1'b0;
            resp_c       <= '0;
            for (int unsigned i = 0; i < NREQ; i++) resp_valid[i] <= 1'b0;
        end else begin
            fpu_in_valid <= 1'b0;
            for (int unsigned i = 0; i < NREQ; i++) resp_valid[i] <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (grant_any) begin
                        fpu_operator <= req_operator[grant_idx];
                        fpu_subop    <= req_subop[grant_idx];
                        fpu_a        <= req_a[grant_idx];
                        fpu_b        <= req_b[grant_idx];
                        owner        <= grant_idx;
                        last_grant   <= grant_idx;
                        fpu_in_valid <= 1'b1;
                        state        <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    wait_cnt <= 16'd1;
                    if (fpu_result_valid) begin
                        resp_c            <= fpu_c;
                        resp_err          <= 1'b0;
                        resp_valid[owner] <= 1'b1;
                        state             <= ARB_RESP;
                    end else begin
                        state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (fpu_result_valid) begin
                        resp_c            <= fpu_c;
                        resp_err          <= 1'b0;
                        resp_valid[owner] <= 1'b1;
                        state             <= ARB_RESP;
                    end else if (wait_cnt == 16'(TIMEOUT)) begin
                        resp_c            <= '0;
                        resp_err          <= 1'b1;
                        resp_valid[owner] <= 1'b1;
                        state             <= ARB_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ARB_RESP: state <= ARB_IDLE;
                default:  state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: FPU stub with programmable latency, a transaction-timeline
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_fpu_arbiter;
    import cpu_pkg::*;

    localparam int NREQ = 2;
    localparam int TO   = 8;

    logic        CLK = 1'b0;
    logic        INITIALIZE = 1'b1;
    logic        req_valid    [NREQ];
    logic [2:0]  req_operator [NREQ];
    logic [2:0]  req_subop    [NREQ];
    logic [31:0] req_a        [NREQ];
    logic [31:0] req_b        [NREQ];
    logic        req_ready    [NREQ];
    logic        resp_valid   [NREQ];
    logic        resp_err;
    logic [31:0] resp_c;
    logic        fpu_in_valid;
    logic [2:0]  fpu_operator, fpu_subop;
    logic [31:0] fpu_a, fpu_b;
    logic        fpu_result_valid;
    logic [31:0] fpu_c = '0;
    logic        busy;

    int   vectors = 0, miscompares = 0;
    int   lat_fixed = 3;          // >=0 fixed latency, -1 never answers, -2 operand-derived 0..20
    logic stub_v = 1'b0, stray = 1'b0;
    assign fpu_result_valid = stub_v | stray;

    fpu_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .CLK(CLK), .INITIALIZE(INITIALIZE),
        .req_valid(req_valid), .req_operator(req_operator), .req_subop(req_subop),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_c(resp_c),
        .fpu_in_valid(fpu_in_valid), .fpu_operator(fpu_operator), .fpu_subop(fpu_subop),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_result_valid(fpu_result_valid),
        .fpu_c(fpu_c), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Monotonic ordering key for non-NaN single-precision values.
    function automatic logic [31:0] ford(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    // Stand-in FPU: exact for the cases the scenarios pin, distinct deterministic values otherwise.
    function automatic logic [31:0] fpu_ref(input logic [2:0] op, input logic [2:0] sub,
                                            input logic [31:0] a, input logic [31:0] b);
        case (op)
            FPU_OP_NEG: return a ^ 32'h8000_0000;
            FPU_OP_ADD: return (a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 : a + b;
            FPU_OP_SUB: return a - b;
            FPU_OP_MUL: return a * b;
            FPU_OP_DIV: return a ^ {b[15:0], b[31:16]};
            FPU_OP_CMP: begin
                case (sub)
                    FPU_CMP_EQ: return {31'b0, a == b};
                    FPU_CMP_LE: return {31'b0, ford(a) <= ford(b)};
                    FPU_CMP_LT: return {31'b0, ford(a) <  ford(b)};
                    default:    return 32'd0;
                endcase
            end
            default: return ~a;
        endcase
    endfunction

    function automatic int lat_of(input logic [31:0] a, input logic [31:0] b);
        if (lat_fixed != -2) return lat_fixed;
        return int'((a ^ b) % 32'd21);
    endfunction

    // FPU stub: one outstanding op; a new issue replaces whatever is still pending.
    int          s_cyc = 0, s_due = 0;
    bit          s_has = 1'b0;
    logic [31:0] s_c = '0;
    always @(posedge CLK) begin : stub
        int l;
        #1;
        s_cyc++;
        stub_v = 1'b0;
        if (fpu_in_valid === 1'b1) begin
            l     = lat_of(fpu_a, fpu_b);
            s_has = (l >= 0);
            s_due = s_cyc + l;
            s_c   = fpu_ref(fpu_operator, fpu_subop, fpu_a, fpu_b);
        end
        if (s_has && s_cyc == s_due) begin
            stub_v = 1'b1;
            fpu_c  = s_c;
            s_has  = 1'b0;
        end
    end

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        check1(name, got, exp);
    endtask

    // Reference model: each accepted op is a timeline (issue at T+1, response at T+2+L
    // or T+2+TO on timeout); the arbiter is idle again the cycle after the response.
    int          k = 0;
    bit          rst_seen = 1'b1;
    bit          m_idle;
    int          m_last, m_owner, m_issue, m_resp;
    int          m_acc [NREQ] = '{default: 0};
    int          resp_seen [NREQ] = '{default: 0};
    logic [2:0]  m_op, m_sub, p_op, p_sub;
    logic [31:0] m_a, m_b, p_a, p_b, m_c, p_c;
    logic        m_err, p_err;

    task automatic model_reset();
        m_idle = 1'b1; m_last = NREQ - 1; m_owner = 0; m_issue = -100; m_resp = -100;
        m_op = '0; m_sub = '0; m_a = '0; m_b = '0; m_c = '0; m_err = 1'b0;
    endtask

    // Single compare process: every cycle, all DUT outputs against the model.
    always @(negedge CLK) begin : model
        int g, best, d, L;
        bit e_rdy [NREQ];
        k++;
        if (rst_seen) model_reset();
        else begin
            if (k == m_issue) begin m_op = p_op; m_sub = p_sub; m_a = p_a; m_b = p_b; end
            if (k == m_resp) begin m_c = p_c; m_err = p_err; end
            if (k == m_resp + 1) m_idle = 1'b1;
        end
        g = -1; best = NREQ;
        for (int p = 0; p < NREQ; p++) begin
            e_rdy[p] = 1'b0;
            if (m_idle && req_valid[p] === 1'b1) begin
                d = (p - m_last - 1 + 2 * NREQ) % NREQ;
                if (d < best) begin best = d; g = p; end
            end
        end
        if (g >= 0) e_rdy[g] = 1'b1;
        vectors++;
        for (int p = 0; p < NREQ; p++) begin
            check1("req_ready",  32'(req_ready[p]),  32'(e_rdy[p]));
            check1("resp_valid", 32'(resp_valid[p]), 32'(k == m_resp && p == m_owner));
            if (resp_valid[p] === 1'b1) resp_seen[p]++;
        end
        check1("fpu_in_valid", 32'(fpu_in_valid), 32'(k == m_issue));
        check1("busy",         32'(busy),         32'(!m_idle));
        check1("resp_err",     32'(resp_err),     32'(m_err));
        check1("resp_c",       resp_c,            m_c);
        check1("fpu_operator", 32'(fpu_operator), 32'(m_op));
        check1("fpu_subop",    32'(fpu_subop),    32'(m_sub));
        check1("fpu_a",        fpu_a,             m_a);
        check1("fpu_b",        fpu_b,             m_b);
        if (g >= 0 && INITIALIZE !== 1'b1) begin
            m_idle = 1'b0; m_last = g; m_owner = g;
            p_op = req_operator[g]; p_sub = req_subop[g]; p_a = req_a[g]; p_b = req_b[g];
            L = lat_of(p_a, p_b);
            m_issue = k + 1;
            if (L >= 0 && L <= TO) begin
                m_resp = k + 2 + L; p_c = fpu_ref(p_op, p_sub, p_a, p_b); p_err = 1'b0;
            end else begin
                m_resp = k + 2 + TO; p_c = '0; p_err = 1'b1;
            end
            m_acc[g]++;
        end
        rst_seen = (INITIALIZE === 1'b1);
    end

    task automatic tick(); @(posedge CLK); #1; endtask
    task automatic obs();  @(negedge CLK);     endtask

    task automatic set_req(input int p, input logic [2:0] op, input logic [2:0] sub,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[p] = 1'b1; req_operator[p] = op; req_subop[p] = sub; req_a[p] = a; req_b[p] = b;
    endtask

    task automatic rand_req(input int p);
        set_req(p, 3'($urandom_range(0, 5)), 3'($urandom_range(0, 2) * 2), $urandom, $urandom);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n, total, found;
        int grants [6];
        int base_acc [NREQ], base_resp [NREQ];
        bit acc [NREQ];
        for (int p = 0; p < NREQ; p++) set_req(p, '0, '0, '0, '0);
        for (int p = 0; p < NREQ; p++) req_valid[p] = 1'b0;

        // Reset values.
        tick(); tick();
        INITIALIZE = 1'b0;
        obs();
        lit("rst_busy", 32'(busy), 32'd0);
        lit("rst_resp_c", resp_c, 32'd0);
        lit("rst_fpu_a", fpu_a, 32'd0);

        // Single ADD on req0, latency 3.
        tick();
        lat_fixed = 3;
        set_req(0, FPU_OP_ADD, 3'b000, 32'h3F80_0000, 32'h4000_0000);
        obs(); lit("t1_ready0", 32'(req_ready[0]), 32'd1);
        tick(); req_valid[0] = 1'b0;
        obs(); lit("t1_issue", 32'(fpu_in_valid), 32'd1); lit("t1_fpu_a", fpu_a, 32'h3F80_0000);
        for (int i = 0; i < 3; i++) begin tick(); obs(); lit("t1_no_reissue", 32'(fpu_in_valid), 32'd0); end
        tick(); obs();
        lit("t1_resp_valid", 32'(resp_valid[0]), 32'd1);
        lit("t1_resp_c", resp_c, 32'h4040_0000);
        lit("t1_resp_err", 32'(resp_err), 32'd0);

        // Reset while idle, then both requesters continuously valid.
        tick(); INITIALIZE = 1'b1;
        tick(); INITIALIZE = 1'b0;
        set_req(0, FPU_OP_MUL, 3'b000, 32'd100, 32'd3);
        set_req(1, FPU_OP_SUB, 3'b000, 32'd200, 32'd7);
        n = 0;
        for (int c = 0; c < 200 && n < 6; c++) begin
            obs();
            found = -1;
            for (int p = 0; p < NREQ; p++) if (req_ready[p] === 1'b1) found = p;
            if (found >= 0) begin grants[n] = found; n++; end
            tick();
            if (found >= 0) begin
                req_a[found] = 32'(n * 16 + found);
                req_b[found] = 32'(n + 5);
            end
        end
        for (int p = 0; p < NREQ; p++) req_valid[p] = 1'b0;
        lit("t2_grant_count", 32'(n), 32'd6);
        for (int i = 0; i < 6; i++) lit("t2_grant_order", 32'(grants[i]), 32'(i % 2));
        repeat (10) tick();

        // CMP LT on req1 with a zero-latency FPU.
        lat_fixed = 0;
        set_req(1, FPU_OP_CMP, FPU_CMP_LT, 32'hBF80_0000, 32'h0000_0000);
        obs(); lit("t3_ready1", 32'(req_ready[1]), 32'd1);
        tick(); req_valid[1] = 1'b0;
        obs(); lit("t3_issue", 32'(fpu_in_valid), 32'd1);
        tick(); obs();
        lit("t3_resp_valid1", 32'(resp_valid[1]), 32'd1);
        lit("t3_resp_c", resp_c, 32'd1);
        tick();

        // FPU never answers: timeout at T+10, then a stray result, then normal service.
        lat_fixed = -1;
        set_req(0, FPU_OP_MUL, 3'b000, 32'd5, 32'd7);
        obs(); lit("t4_ready0", 32'(req_ready[0]), 32'd1);
        tick(); req_valid[0] = 1'b0;
        repeat (9) tick();
        obs();
        lit("t4_to_valid", 32'(resp_valid[0]), 32'd1);
        lit("t4_to_err", 32'(resp_err), 32'd1);
        lit("t4_to_c", resp_c, 32'd0);
        repeat (4) tick();
        stray = 1'b1;
        tick(); stray = 1'b0;
        obs();
        lit("t4_stray_ignored", 32'(resp_valid[0]), 32'd0);
        lit("t4_stray_idle", 32'(busy), 32'd0);
        tick();
        lat_fixed = 3;
        set_req(0, FPU_OP_SUB, 3'b000, 32'd10, 32'd3);
        obs(); lit("t4_ready_again", 32'(req_ready[0]), 32'd1);
        tick(); req_valid[0] = 1'b0;
        repeat (4) tick();
        obs();
        lit("t4_next_valid", 32'(resp_valid[0]), 32'd1);
        lit("t4_next_c", resp_c, 32'd7);
        lit("t4_next_err", 32'(resp_err), 32'd0);
        tick();

        // Reset in WAIT: no response, reset values, next grant to requester 0.
        lat_fixed = 5;
        set_req(0, FPU_OP_DIV, 3'b000, 32'h1234_5678, 32'h0000_0009);
        obs(); lit("t5_ready0", 32'(req_ready[0]), 32'd1);
        tick(); req_valid[0] = 1'b0;
        tick();
        tick(); INITIALIZE = 1'b1;
        tick(); INITIALIZE = 1'b0;
        obs();
        lit("t5_busy", 32'(busy), 32'd0);
        lit("t5_fpu_a", fpu_a, 32'd0);
        lit("t5_resp_c", resp_c, 32'd0);
        lit("t5_resp_valid", 32'(resp_valid[0]), 32'd0);
        repeat (5) tick();
        lat_fixed = 3;
        set_req(0, FPU_OP_ADD, 3'b000, 32'd1, 32'd2);
        set_req(1, FPU_OP_ADD, 3'b000, 32'd3, 32'd4);
        obs();
        lit("t5_grant0", 32'(req_ready[0]), 32'd1);
        lit("t5_not1", 32'(req_ready[1]), 32'd0);
        tick(); req_valid[0] = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            obs();
            if (req_ready[1] === 1'b1) found = 1;
            tick();
        end
        req_valid[1] = 1'b0;
        lit("t5_req1_served", 32'(found), 32'd1);
        repeat (10) tick();

        // Random mix with operand-derived latency 0..20 (timeouts included).
        lat_fixed = -2;
        for (int p = 0; p < NREQ; p++) begin base_acc[p] = m_acc[p]; base_resp[p] = resp_seen[p]; end
        for (int p = 0; p < NREQ; p++) rand_req(p);
        total = 0;
        for (int c = 0; c < 40000 && total < 1000; c++) begin
            obs();
            for (int p = 0; p < NREQ; p++) begin
                acc[p] = (req_ready[p] === 1'b1);
                if (acc[p]) total++;
            end
            tick();
            for (int p = 0; p < NREQ; p++) begin
                if (acc[p] || !req_valid[p]) begin
                    if ($urandom_range(0, 3) != 0) rand_req(p);
                    else req_valid[p] = 1'b0;
                end
            end
        end
        for (int p = 0; p < NREQ; p++) req_valid[p] = 1'b0;
        repeat (30) tick();
        lit("t6_ops_done", 32'(total), 32'd1000);
        for (int p = 0; p < NREQ; p++)
            lit("t6_resp_count", 32'(resp_seen[p] - base_resp[p]), 32'(m_acc[p] - base_acc[p]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
